// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- registered arithmetic / logic / shift unit
//
// Computes a result from a, b, c_in and select combinationally and captures
// it into y on every rising clk edge (one cycle of latency, no handshake).
//
// Ports
//   y      : out, WIDTH     registered result
//   a      : in,  WIDTH     operand A
//   b      : in,  WIDTH     operand B
//   c_in   : in,  1         carry-in / arithmetic variant selector
//   select : in,  SEL_WIDTH opcode
//   clk    : in,  1         clock, rising edge
//   rst    : in,  1         asynchronous active-high reset, clears outputs
//   c_out  : out, 1         registered carry (only with ALU_CARRY_OUT_EN)
//
// Opcode map
//   select[4:3]=00 : select[2]=0 arithmetic, select[2]=1 logic,
//                    select[1:0] picks the operation
//   select[4:3]=01 : a << 1
//   select[4:3]=10 : a >> 1 (logical)
//   select[4:3]=11 : zero
//
// Configuration
//   ALU_CARRY_OUT_EN : when defined, adds the registered c_out port.
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH     = 4,
  parameter int SEL_WIDTH = 5
) (
  output logic [WIDTH-1:0]     y,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 c_in,
  input  logic [SEL_WIDTH-1:0] select,
  input  logic                 clk,
  input  logic                 rst
`ifdef ALU_CARRY_OUT_EN
  ,
  output logic                 c_out
`endif
);

  // The adder carries one extra bit only when the carry is actually exported,
  // so the default build has no dangling carry logic.
`ifdef ALU_CARRY_OUT_EN
  localparam int SUM_W = WIDTH + 1;
`else
  localparam int SUM_W = WIDTH;
`endif

  logic [WIDTH-1:0] next_y;
  logic [WIDTH-1:0] op_b;
  logic [SUM_W-1:0] sum;
`ifdef ALU_CARRY_OUT_EN
  logic             next_c;
`endif

  // All four arithmetic ops share one adder: a + op_b + c_in, where op_b is
  // 0, b, ~b or all-ones. Op 011 with c_in=1 bypasses the adder (transfer B).
  always_comb begin
    op_b = '0;
    unique case (select[1:0])
      2'b00:   op_b = '0;
      2'b01:   op_b = b;
      2'b10:   op_b = ~b;
      default: op_b = '1;
    endcase
  end

  // For a-1 (op 011, c_in=0) the carry-in must be zero, which it already is.
  assign sum = SUM_W'(a) + SUM_W'(op_b) + SUM_W'(c_in);

  always_comb begin
    next_y = '0;
`ifdef ALU_CARRY_OUT_EN
    next_c = 1'b0;
`endif
    unique case (select[4:3])
      2'b00: begin
        if (!select[2]) begin
          if (select[1:0] == 2'b11 && c_in) begin
            next_y = b;
          end else begin
            next_y = sum[WIDTH-1:0];
`ifdef ALU_CARRY_OUT_EN
            next_c = sum[WIDTH];
`endif
          end
        end else begin
          unique case (select[1:0])
            2'b00:   next_y = a & b;
            2'b01:   next_y = a | b;
            2'b10:   next_y = a ^ b;
            default: next_y = ~a;
          endcase
        end
      end
      2'b01: begin
        next_y = {a[WIDTH-2:0], 1'b0};
`ifdef ALU_CARRY_OUT_EN
        next_c = a[WIDTH-1];
`endif
      end
      2'b10: begin
        next_y = {1'b0, a[WIDTH-1:1]};
`ifdef ALU_CARRY_OUT_EN
        next_c = a[0];
`endif
      end
      default: begin
        next_y = '0;
      end
    endcase
  end

  // Output register; reset clears it immediately and drops any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else begin
      y <= next_y;
    end
  end

`ifdef ALU_CARRY_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_out <= 1'b0;
    end else begin
      c_out <= next_c;
    end
  end
`endif

  // select[SEL_WIDTH-1:5] does not exist for the fixed 5-bit encoding.
endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- directed and swept checks for the 4-bit default alu.
// Define ALU_CARRY_OUT_EN for both files to also check c_out.
// ---------------------------------------------------------------------------
module tb_alu;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic [W-1:0] y;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [4:0]   select;
  logic         clk;
  logic         rst;
`ifdef ALU_CARRY_OUT_EN
  logic         c_out;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  alu #(.WIDTH(W), .SEL_WIDTH(5)) dut (
    .y(y),
    .a(a),
    .b(b),
    .c_in(c_in),
    .select(select),
    .clk(clk),
    .rst(rst)
`ifdef ALU_CARRY_OUT_EN
    ,
    .c_out(c_out)
`endif
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs on the falling edge, let one rising edge capture them,
  // then sample 1 unit later.
  task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic vc, input logic [4:0] vsel);
    @(negedge clk);
    a = va;
    b = vb;
    c_in = vc;
    select = vsel;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] exp_y,
                             input logic exp_c);
    tests_run++;
    assert (y === exp_y) else begin
      tests_failed++;
      $error("[TB] FAIL %s: y=%b expected %b", tag, y, exp_y);
    end
`ifdef ALU_CARRY_OUT_EN
    tests_run++;
    assert (c_out === exp_c) else begin
      tests_failed++;
      $error("[TB] FAIL %s c_out: got %b expected %b", tag, c_out, exp_c);
    end
`else
    if (exp_c) begin
    end
`endif
  endtask

  // Reference computed with integer arithmetic on the opcode value.
  task automatic refModel(input int va, input int vb, input int vc, input int vsel,
                          output logic [W-1:0] ry, output logic rc);
    int r;
    r = 0;
    rc = 1'b0;
    if (vsel < 8) begin
      case (vsel)
        0: r = va + vc;
        1: r = va + vb + vc;
        2: r = va + (M - 1 - vb) + vc;
        3: r = (vc == 1) ? vb : va + (M - 1);
        4: r = va & vb;
        5: r = va | vb;
        6: r = va ^ vb;
        default: r = (M - 1) - va;
      endcase
      ry = W'(r % M);
      rc = (vsel < 4 && !(vsel == 3 && vc == 1) && r >= M);
    end else if (vsel < 16) begin
      ry = W'((va * 2) % M);
      rc = (va >= M / 2);
    end else if (vsel < 24) begin
      ry = W'(va / 2);
      rc = (va % 2 == 1);
    end else begin
      ry = '0;
    end
  endtask

  initial begin
    logic [W-1:0] exp_y;
    logic         exp_c;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc_in;

    a = '0;
    b = '0;
    c_in = 1'b0;
    select = '0;
    rst = 1'b1;

    // Reset holds outputs at zero before any clock edge.
    #2;
    checkOutput("reset_initial", 4'b0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Arithmetic ops with a=1010, b=0101
    applyStimulus(4'b1010, 4'b0101, 1'b0, 5'd0);  checkOutput("op0_cin0", 4'b1010, 1'b0);
    applyStimulus(4'b1010, 4'b0101, 1'b1, 5'd0);  checkOutput("op0_cin1", 4'b1011, 1'b0);
    applyStimulus(4'b1010, 4'b0101, 1'b0, 5'd1);  checkOutput("op1_cin0", 4'b1111, 1'b0);
    applyStimulus(4'b1010, 4'b0101, 1'b1, 5'd1);  checkOutput("op1_cin1", 4'b0000, 1'b1);
    applyStimulus(4'b1010, 4'b0101, 1'b0, 5'd2);  checkOutput("op2_cin0", 4'b0100, 1'b1);
    applyStimulus(4'b1010, 4'b0101, 1'b1, 5'd2);  checkOutput("op2_cin1", 4'b0101, 1'b1);
    applyStimulus(4'b1010, 4'b0101, 1'b0, 5'd3);  checkOutput("op3_cin0", 4'b1001, 1'b1);
    applyStimulus(4'b1010, 4'b0101, 1'b1, 5'd3);  checkOutput("op3_cin1", 4'b0101, 1'b0);

    // Logic ops ignore c_in
    applyStimulus(4'b1010, 4'b0101, 1'b1, 5'd4);  checkOutput("and", 4'b0000, 1'b0);
    applyStimulus(4'b1010, 4'b0101, 1'b0, 5'd5);  checkOutput("or", 4'b1111, 1'b0);
    applyStimulus(4'b1010, 4'b0101, 1'b1, 5'd6);  checkOutput("xor", 4'b1111, 1'b0);
    applyStimulus(4'b1010, 4'b0101, 1'b0, 5'd7);  checkOutput("not_a", 4'b0101, 1'b0);

    // Shifts and zero
    applyStimulus(4'b1010, 4'b0101, 1'b0, 5'd8);  checkOutput("shl", 4'b0100, 1'b1);
    applyStimulus(4'b1010, 4'b0101, 1'b1, 5'd16); checkOutput("shr", 4'b0101, 1'b0);
    applyStimulus(4'b1010, 4'b0101, 1'b1, 5'd24); checkOutput("zero", 4'b0000, 1'b0);
    applyStimulus(4'b1010, 4'b0101, 1'b1, 5'd13); checkOutput("shl_lowbits", 4'b0100, 1'b1);
    applyStimulus(4'b0011, 4'b0110, 1'b1, 5'd19); checkOutput("shr_lowbits", 4'b0001, 1'b1);
    applyStimulus(4'b1111, 4'b1111, 1'b1, 5'd31); checkOutput("zero_all_ones", 4'b0000, 1'b0);

    // Wrap-around boundaries
    applyStimulus(4'b1111, 4'b0000, 1'b1, 5'd0);  checkOutput("inc_wrap", 4'b0000, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 5'd3);  checkOutput("dec_wrap", 4'b1111, 1'b0);
    applyStimulus(4'b1111, 4'b1111, 1'b1, 5'd1);  checkOutput("add_max", 4'b1111, 1'b1);

    // Asynchronous reset between edges, then first edge loads new inputs
    applyStimulus(4'b1010, 4'b0101, 1'b0, 5'd5);  checkOutput("pre_reset", 4'b1111, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset_async", 4'b0000, 1'b0);
    a = 4'b0011;
    b = 4'b0000;
    c_in = 1'b0;
    select = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("after_reset", 4'b0011, 1'b0);

    // Reset held across an edge discards the pending result
    applyStimulus(4'b1010, 4'b0101, 1'b1, 5'd1);  checkOutput("pre_discard", 4'b0000, 1'b1);
    @(negedge clk);
    a = 4'b0111;
    select = 5'd7;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_discard", 4'b0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_release_hold", 4'b0000, 1'b0);

    // Only the values present at the edge are captured
    @(negedge clk);
    a = 4'b0001; b = 4'b0001; c_in = 1'b0; select = 5'd1;
    #3;
    a = 4'b0110; select = 5'd6;
    @(posedge clk);
    #1;
    checkOutput("late_change", 4'b0111, 1'b0);

    // Full opcode sweep with random operands
    for (int s = 0; s < 32; s++) begin
      for (int k = 0; k < 4; k++) begin
        ra = W'($urandom_range(0, M - 1));
        rb = W'($urandom_range(0, M - 1));
        rc_in = 1'($urandom_range(0, 1));
        refModel(int'(ra), int'(rb), int'(rc_in), s, exp_y, exp_c);
        applyStimulus(ra, rb, rc_in, 5'(s));
        checkOutput($sformatf("sweep_sel%0d_a%0d_b%0d_c%0d", s, ra, rb, rc_in), exp_y, exp_c);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
